// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the hazard/stall controller: decode and EX hazard
// inputs plus the stall/flush enables it drives back into the pipeline.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rd_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic             md_valid_ex;
  logic             redirect_id;
  logic             stall_pc;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             bubble_ex_wb;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, reg_write_ex,
           mem_read_ex, md_valid_ex, redirect_id,
    input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           bubble_ex_wb, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, reg_write_ex,
           mem_read_ex, md_valid_ex, redirect_id,
    output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           bubble_ex_wb, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the IF/ID/EX/WB core: load-use stall, multi-cycle
// mul/div freeze of EX, redirect flush of IF/ID, and a saturating stall counter.
module hazard_stall_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam int unsigned MD_LOAD_I = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;
  localparam logic [3:0]  MD_LOAD   = 4'(MD_LOAD_I);
  localparam bit          MD_MULTI  = (MD_LATENCY > 1);

  state_t           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic stall_pc, stall_if_id, stall_id_ex;
  logic flush_if_id, flush_id_ex, bubble_ex_wb;
  logic md_busy, md_done;

  // Unused source operands are masked so their (possibly X) values never matter.
  always_comb begin
    load_use = 1'b0;
    if (hz.mem_read_ex && hz.reg_write_ex && (hz.rd_ex != 5'd0)) begin
      if (hz.use_rs1_id && (hz.rs1_id == hz.rd_ex)) load_use = 1'b1;
      if (hz.use_rs2_id && (hz.rs2_id == hz.rd_ex)) load_use = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (stall_pc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      RUN: begin
        if (hz.md_valid_ex && MD_MULTI) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
        else                  state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    bubble_ex_wb = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.md_valid_ex) begin
          if (MD_MULTI) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            bubble_ex_wb = 1'b1;
          end else begin
            md_done = 1'b1;
          end
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy = 1'b1;
        if (md_cnt_q != 4'd0) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          bubble_ex_wb = 1'b1;
        end else begin
          md_done = 1'b1;
        end
      end
      default: ;
    endcase
    flush_if_id = hz.redirect_id && !stall_pc;
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_if_id  = stall_if_id;
  assign hz.stall_id_ex  = stall_id_ex;
  assign hz.flush_if_id  = flush_if_id;
  assign hz.flush_id_ex  = flush_id_ex;
  assign hz.bubble_ex_wb = bubble_ex_wb;
  assign hz.md_busy      = md_busy;
  assign hz.md_done      = md_done;
  assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: expected outputs are queued
// when each step's inputs are driven and compared mid-cycle.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(32)) bus ();
  hazard_stall_unit_if #(.CNT_W(4))  bus2 ();

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .hz  (bus2)
  );

  typedef struct {
    logic        spc, sif, sie, fif, fie, bub, busy, done;
    bit          busy_dc;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sc_model = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.use_rs1_id = 1'b0; bus.use_rs2_id = 1'b0;
    bus.rd_ex = '0; bus.reg_write_ex = 1'b0; bus.mem_read_ex = 1'b0;
    bus.md_valid_ex = 1'b0; bus.redirect_id = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2);
    bus.mem_read_ex = 1'b1; bus.reg_write_ex = 1'b1; bus.rd_ex = rd;
    bus.rs1_id = r1; bus.use_rs1_id = u1; bus.rs2_id = r2; bus.use_rs2_id = u2;
  endtask

  // Push the expectation for the cycle just driven, compare at negedge, advance.
  task automatic step(input string tag, input logic spc, sif, sie, fif, fie, bub,
                      busy, done, input bit busy_dc = 1'b0);
    exp_t e, g;
    e.spc = spc; e.sif = sif; e.sie = sie; e.fif = fif; e.fie = fie;
    e.bub = bub; e.busy = busy; e.done = done; e.busy_dc = busy_dc; e.sc = sc_model;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk({tag, ".stall_pc"},     32'(bus.stall_pc),     32'(g.spc));
    chk({tag, ".stall_if_id"},  32'(bus.stall_if_id),  32'(g.sif));
    chk({tag, ".stall_id_ex"},  32'(bus.stall_id_ex),  32'(g.sie));
    chk({tag, ".flush_if_id"},  32'(bus.flush_if_id),  32'(g.fif));
    chk({tag, ".flush_id_ex"},  32'(bus.flush_id_ex),  32'(g.fie));
    chk({tag, ".bubble_ex_wb"}, 32'(bus.bubble_ex_wb), 32'(g.bub));
    if (!g.busy_dc) chk({tag, ".md_busy"}, 32'(bus.md_busy), 32'(g.busy));
    chk({tag, ".md_done"},      32'(bus.md_done),      32'(g.done));
    chk({tag, ".stall_cycles"}, bus.stall_cycles,      g.sc);
    if (rst)                              sc_model = '0;
    else if (g.spc && (sc_model != '1))   sc_model = sc_model + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    bus2.rs1_id = '0; bus2.rs2_id = '0; bus2.use_rs1_id = 1'b0; bus2.use_rs2_id = 1'b0;
    bus2.rd_ex = '0; bus2.reg_write_ex = 1'b0; bus2.mem_read_ex = 1'b0;
    bus2.md_valid_ex = 1'b0; bus2.redirect_id = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step("reset", 0,0,0,0,0,0,0,0);

    // load-use on rs1 with a redirect that must be suppressed
    load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); bus.redirect_id = 1'b1;
    step("lu_rs1", 1,1,0,0,1,0,0,0);
    clr(); bus.redirect_id = 1'b1;
    step("lu_after", 0,0,0,1,0,0,0,0);

    clr(); load(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("lu_rd0", 0,0,0,0,0,0,0,0);
    clr(); load(5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    step("lu_mask", 0,0,0,0,0,0,0,0);
    clr(); bus.reg_write_ex = 1'b1; bus.rd_ex = 5'd7; bus.rs2_id = 5'd7; bus.use_rs2_id = 1'b1;
    step("nonload", 0,0,0,0,0,0,0,0);
    clr(); load(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    step("lu_rs2", 1,1,0,0,1,0,0,0);

    // mul/div op held in EX; a coincident load-use must lose to it
    clr(); bus.md_valid_ex = 1'b1; load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step("md_c1", 1,1,1,0,0,1,0,0);
    clr(); bus.md_valid_ex = 1'b1; bus.redirect_id = 1'b1;
    step("md_c2", 1,1,1,0,0,1,1,0);
    clr(); bus.md_valid_ex = 1'b1;
    step("md_c3", 1,1,1,0,0,1,1,0);
    clr();
    step("md_c4", 0,0,0,0,0,0,0,1, 1'b1);
    step("md_run", 0,0,0,0,0,0,0,0);

    // reset during the second MD_BUSY cycle
    bus.md_valid_ex = 1'b1;
    step("rs_c1", 1,1,1,0,0,1,0,0);
    step("rs_c2", 1,1,1,0,0,1,1,0);
    rst = 1'b1;
    step("rs_c3", 1,1,1,0,0,1,1,0);
    rst = 1'b0; clr();
    step("rs_after", 0,0,0,0,0,0,0,0);
    step("rs_after2", 0,0,0,0,0,0,0,0);

    // saturation of a 4-bit counter under a continuous load-use stall
    bus2.mem_read_ex = 1'b1; bus2.reg_write_ex = 1'b1; bus2.rd_ex = 5'd4;
    bus2.rs1_id = 5'd4; bus2.use_rs1_id = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("sat_stall_pc[%0d]", k), 32'(bus2.stall_pc), 32'd1);
      chk($sformatf("sat_cnt[%0d]", k), 32'(bus2.stall_cycles), (k > 15) ? 32'd15 : 32'(k));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
